pipe_mul_sequencer: RTL

//   Multi-cycle multiply controller for the EX stage of the 5-stage pipeline.

---
 rtl/pipe_mul_sequencer_pkg.sv | 15 +
 rtl/pipe_mul_sequencer_step.sv | 28 ++
 rtl/pipe_mul_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/pipe_mul_sequencer_pkg.sv
// Shared definitions for the EX-stage multiply sequencer: the ALU control code
// that selects a multiply and the controller's state encoding.
package pipe_mul_sequencer_pkg;

    // ALU control code for mul/muli; the ID control unit decodes with the same value.
    localparam logic [4:0] ALUC_MUL = 5'b00001;

    // Sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_mul_sequencer_step.sv
// One shift-add step: acc + mcand * digit, where digit is RADIX_BITS wide.
// Built as conditional shifted adds so no full-width multiplier is inferred.
// All sums wrap mod 2^WIDTH.
module pipe_mul_sequencer_step #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic [WIDTH-1:0]      acc_i,
    input  logic [WIDTH-1:0]      mcand_i,
    input  logic [RADIX_BITS-1:0] digit_i,
    output logic [WIDTH-1:0]      sum_o
);

    logic [WIDTH-1:0] sum;

    // Accumulate mcand shifted by each set digit bit.
    always_comb begin
        sum = acc_i;
        for (int i = 0; i < RADIX_BITS; i++) begin
            if (digit_i[i]) begin
                sum = sum + (mcand_i << i);
            end
        end
    end

    assign sum_o = sum;

endmodule

// File: rtl/pipe_mul_sequencer.sv
// Multi-cycle multiply controller for the EX stage. A mul held in EX is
// latched on the IDLE->RUN transition, then RADIX_BITS multiplier bits are
// retired per cycle. The pipeline is stalled until the product is committed
// to the result register and done pulses for one cycle.
//
// Handshake: start is a level from EX, not a pulse. It is accepted only in
// IDLE and only without cancel. While start is held through DONE it is
// ignored, because it is the same instruction that is still in EX. The
// instruction leaves EX at the end of the DONE cycle. cancel aborts RUN with
// no done and no change to result.
module pipe_mul_sequencer
    import pipe_mul_sequencer_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       dbg_state
);

    localparam int N     = WIDTH / RADIX_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] step_sum;

    pipe_mul_sequencer_step #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .digit_i (mplier_q[RADIX_BITS-1:0]),
        .sum_o   (step_sum)
    );

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
        end
    end

    // Next-state and datapath update. Cancel takes priority over finishing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    state_d  = S_RUN;
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d    = step_sum;
                    mcand_d  = mcand_q << RADIX_BITS;
                    mplier_d = mplier_q >> RADIX_BITS;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d  = S_DONE;
                        result_d = step_sum;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign stall     = ((state_q == S_IDLE) && start && !cancel) || (state_q == S_RUN);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule
